// File: rtl/iob_mem_responder_pkg.sv
// Shared types and constants for the IOb memory responder: FSM encoding, error data word and
// request-queue entry width.
package iob_mem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [31:0] ErrData = 32'hDEADBEEF;

  // Queue entry is {address, wdata, wstrb}.
  function automatic int unsigned entry_width(int unsigned addr_w, int unsigned data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/iob_mem_responder_sync_fifo.sv
// Request queue for the IOb memory responder: synchronous reset, push accepted while full when a
// pop happens in the same cycle.
module iob_mem_responder_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/iob_mem_responder.sv
// IOb native-bus responder backed by a RAM; requests are queued and answered in order after
// LATENCY cycles. Optional address range check: define IOB_MEM_RESP_ADDR_CHK_EN.
module iob_mem_responder
  import iob_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_ADDR_W = 12,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned REQ_W     = 1 + entry_width(ADDR_W, DATA_W),
  localparam int unsigned RESP_W    = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  req,
  output logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              overflow,
  output logic              addr_err
);

  localparam int unsigned StrbW  = DATA_W / 8;
  localparam int unsigned EntryW = entry_width(ADDR_W, DATA_W);
  localparam int unsigned CntW   = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [EntryW-1:0]  work_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               ready_q, overflow_q, err_q;
  logic [DATA_W-1:0]  mem_q [2**MEM_ADDR_W];

  logic               valid, full, empty, pop, enter_resp, addr_bad;
  logic [EntryW-1:0]  head, cur;
  logic [ADDR_W-1:0]  cur_addr;
  logic [DATA_W-1:0]  cur_wdata;
  logic [StrbW-1:0]   cur_strb;
  logic [MEM_ADDR_W-1:0] idx;

  assign valid = req[REQ_W-1];
  assign pop   = (state_q == StIdle) && !empty;

  iob_mem_responder_sync_fifo #(
    .WIDTH(EntryW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (valid),
    .data_i (req[EntryW-1:0]),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  // From IDLE the request being launched is still at the queue head, not yet in work_q.
  assign cur       = (state_q == StIdle) ? head : work_q;
  assign cur_addr  = cur[EntryW-1 -: ADDR_W];
  assign cur_wdata = cur[StrbW +: DATA_W];
  assign cur_strb  = cur[StrbW-1:0];
  assign idx       = cur_addr[MEM_ADDR_W+1:2];

  assign enter_resp = (pop && (LATENCY == 2)) || ((state_q == StWait) && (cnt_q == '0));

`ifdef IOB_MEM_RESP_ADDR_CHK_EN
  assign addr_bad = |cur_addr[ADDR_W-1:MEM_ADDR_W+2];
`else
  assign addr_bad = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^{cur_addr[ADDR_W-1:MEM_ADDR_W+2], cur_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      work_q     <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (valid && full && !pop) overflow_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            work_q <= head;
            if (LATENCY == 2) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntW'(LATENCY - 3);
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) state_q <= StResp;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (enter_resp) begin
        ready_q <= 1'b1;
        err_q   <= addr_bad;
        rdata_q <= addr_bad ? DATA_W'(ErrData) : mem_q[idx];
      end
    end
  end

  // RAM is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && !addr_bad) begin
      for (int i = 0; i < int'(StrbW); i++) begin
        if (cur_strb[i]) mem_q[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign resp     = {rdata_q, ready_q};
  assign busy     = (state_q != StIdle) || !empty;
  assign overflow = overflow_q;
  assign addr_err = err_q;

endmodule
